// File: rtl/linebuf_pkg.sv
// Shared definitions for the sprite line-buffer ping-pong controller:
// pen geometry, writer FSM states and pen helpers.
package linebuf_pkg;

  // Pen occupies the low bits of every pixel; pen 0 is transparent.
  localparam int PEN_W = 4;
  localparam logic [PEN_W-1:0] TRANSPARENT_PEN = '0;

  // Writer read-modify-write sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } wr_state_t;

  // Callers pass the low PEN_W bits of a pixel, so the helper does not
  // depend on the pixel width.
  function automatic logic [PEN_W-1:0] pen_of(input logic [PEN_W-1:0] pix_lo);
    return pix_lo;
  endfunction

  function automatic logic pen_opaque(input logic [PEN_W-1:0] pen);
    return pen != TRANSPARENT_PEN;
  endfunction

endpackage

// File: rtl/linebuf_pingpong_ctrl_bank.sv
// One scanline bank: port 0 read/write with registered read data
// (read-before-write), port 1 write-only, used for clear-behind-the-beam.
// Contents are not reset.
module linebuf_bank #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 11
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a0,
  input  logic              we0,
  input  logic [PIX_W-1:0]  d0,
  output logic [PIX_W-1:0]  q0,
  input  logic [ADDR_W-1:0] a1,
  input  logic              we1,
  input  logic [PIX_W-1:0]  d1
);

  logic [PIX_W-1:0] mem [2**ADDR_W];

  // Both write ports plus the registered port-0 read.
  always_ff @(posedge clk) begin
    if (we0) mem[a0] <= d0;
    if (we1) mem[a1] <= d1;
    q0 <= mem[a0];
  end

endmodule

// File: rtl/linebuf_pingpong_ctrl.sv
// Ping-pong scanline buffer controller for the sprite path.
// The display side reads bank disp_bank with one cycle of latency and can
// clear each location behind the beam. The writer does a 3-cycle
// read-modify-write into the other bank, so the first opaque pixel wins.
// Optional build macro: LINEBUF_COLLIDE_EN enables the sticky collide flag.
module linebuf_pingpong_ctrl
  import linebuf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              swap,
  input  logic [ADDR_W-1:0] rd_x,
  input  logic              rd_clr_en,
  output logic [PIX_W-1:0]  rd_pix,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic [PIX_W-1:0]  wr_pix,
  output logic              wr_ack,
  output logic              wr_busy,
  output logic              disp_bank,
  output logic              collide,
  input  logic              collide_clr
);

  wr_state_t state_reg, state_next;

  logic              disp_bank_reg;
  logic              rd_bank_reg;
  logic              rd_live_reg;
  logic              clr_en_reg;
  logic [ADDR_W-1:0] clr_x_reg;

  logic [ADDR_W-1:0] wx_reg;
  logic [PIX_W-1:0]  wpix_reg;
  logic              wbank_reg;

  logic [1:0][PIX_W-1:0] q0;
  logic                  wr_active;
  logic                  in_wr;
  logic [PEN_W-1:0]      old_pen;
  logic [PEN_W-1:0]      new_pen;
  logic                  wr_commit;

  assign wr_active = (state_reg != IDLE);
  assign in_wr     = (state_reg == WR);
  assign old_pen   = pen_of(q0[wbank_reg][PEN_W-1:0]);
  assign new_pen   = pen_of(wpix_reg[PEN_W-1:0]);
  // Reset landing on the WR cycle still drops the write.
  assign wr_commit = in_wr && !reset && pen_opaque(new_pen) && !pen_opaque(old_pen);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic              own_wr;
      logic [ADDR_W-1:0] a0;
      logic              we0;
      logic              we1;

      // The writer owns port 0 of its latched bank while busy. If that bank
      // became the display bank through a swap, the writer still wins and
      // the display read glitches.
      assign own_wr = wr_active && (wbank_reg == 1'(gi));
      assign a0     = own_wr ? wx_reg : rd_x;
      assign we0    = own_wr && wr_commit;
      assign we1    = clr_en_reg && (rd_bank_reg == 1'(gi));

      linebuf_bank #(
        .ADDR_W(ADDR_W),
        .PIX_W (PIX_W)
      ) u_bank (
        .clk(clk),
        .a0 (a0),
        .we0(we0),
        .d0 (wpix_reg),
        .q0 (q0[gi]),
        .a1 (clr_x_reg),
        .we1(we1),
        .d1 ('0)
      );
    end
  endgenerate

  // Control state: FSM, bank role, display pipeline valid and clear strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      disp_bank_reg <= 1'b0;
      rd_live_reg   <= 1'b0;
      clr_en_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_live_reg <= 1'b1;
      clr_en_reg  <= rd_clr_en;
      if (swap) disp_bank_reg <= ~disp_bank_reg;
    end
  end

  // Datapath latches. The display read bank is pinned to the pre-swap value,
  // and the writer request is captured on acceptance.
  always_ff @(posedge clk) begin
    rd_bank_reg <= disp_bank_reg;
    clr_x_reg   <= rd_x;
    if (state_reg == IDLE && wr_req) begin
      wx_reg    <= wr_x;
      wpix_reg  <= wr_pix;
      wbank_reg <= ~disp_bank_reg;
    end
  end

  // Writer sequencer next state and ack.
  always_comb begin
    state_next = state_reg;
    wr_ack     = 1'b0;
    case (state_reg)
      IDLE: if (wr_req) state_next = RD;
      RD:   state_next = WR;
      WR: begin
        state_next = IDLE;
        wr_ack     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_busy   = wr_active;
  assign disp_bank = disp_bank_reg;
  assign rd_pix    = rd_live_reg ? q0[rd_bank_reg] : '0;

`ifdef LINEBUF_COLLIDE_EN
  logic collide_reg;
  logic collide_set;

  assign collide_set = in_wr && pen_opaque(new_pen) && pen_opaque(old_pen);

  // Sticky collision flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)            collide_reg <= 1'b0;
    else if (collide_set) collide_reg <= 1'b1;
    else if (collide_clr) collide_reg <= 1'b0;
  end

  assign collide = collide_reg;
`else
  logic unused_collide_clr;
  assign unused_collide_clr = collide_clr;
  assign collide = 1'b0;
`endif

endmodule
